// File: rtl/mctp_spi_mstr_arb_pkg.sv
// Shared types and constants for the two-requester SPI-master AVMM arbiter.
//   arb_state_e : arbiter FSM states
//   OWNER_R0/R1 : one-hot owner encodings driven on arb_owner
//   TO_CNT_W    : width of the read-response timeout counter
//   DATA_WIDTH  : AVMM data width on every port
package mctp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_CMD  = 2'd2,
        ST_RD_WAIT = 2'd3
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_R0   = 2'b01;
    localparam logic [1:0] OWNER_R1   = 2'b10;

    localparam int unsigned TO_CNT_W   = 16;
    localparam int unsigned DATA_WIDTH = 32;

endpackage

// File: rtl/mctp_spi_mstr_arb_if.sv
// AVMM link bundle used for both requester ports and the SPI-master port.
//   master : drives addr/write/read/burstcnt/wrdata, receives rddata/rddvld/waitreq
//   slave  : the opposite direction
interface mctp_spi_mstr_arb_if
    import mctp_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned BRST_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic                  read;
    logic [BRST_WIDTH-1:0] burstcnt;
    logic [DATA_WIDTH-1:0] wrdata;
    logic [DATA_WIDTH-1:0] rddata;
    logic                  rddvld;
    logic                  waitreq;

    modport master (
        output addr, write, read, burstcnt, wrdata,
        input  rddata, rddvld, waitreq
    );

    modport slave (
        input  addr, write, read, burstcnt, wrdata,
        output rddata, rddvld, waitreq
    );
endinterface

// File: rtl/mctp_spi_mstr_arb.sv
// Round-robin arbiter sharing one SPI-master AVMM port between two requesters.
// The grant is held for a full write or read burst; read data is steered only
// to the owner and stalled reads are abandoned after TIMEOUT_US pulse_1us ticks.
//   clk, reset   : clock, synchronous active-high reset
//   pulse_1us    : single-cycle 1 us strobe feeding the read timeout
//   r0, r1       : requester AVMM ports (r0 = MCTP VDM ingress, r1 = PMCI sideband)
//   m            : AVMM port toward the SPI master
//   arb_owner    : one-hot current owner, 00 when idle
//   arb_timeout  : one-cycle pulse when a read is abandoned
module mctp_spi_mstr_arb
    import mctp_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned BRST_WIDTH = 9,
    parameter int unsigned TIMEOUT_US = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pulse_1us,
    mctp_spi_mstr_arb_if.slave         r0,
    mctp_spi_mstr_arb_if.slave         r1,
    mctp_spi_mstr_arb_if.master        m,
    output logic [1:0]                 arb_owner,
    output logic                       arb_timeout
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_US - 1);

    arb_state_e            state_q, state_d;
    logic [1:0]            owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;   // 1: r1 was served last
    logic [BRST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                  first_q, first_d;             // next write beat is the first
    logic [BRST_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic                  timeout_q, timeout_d;

    logic                  sel_r1_c;
    logic [ADDR_WIDTH-1:0] own_addr_c;
    logic                  own_write_c;
    logic                  own_read_c;
    logic [BRST_WIDTH-1:0] own_burst_c;
    logic [BRST_WIDTH-1:0] eff_burst_c;
    logic [DATA_WIDTH-1:0] own_wrdata_c;
    logic                  m_write_c;
    logic                  m_read_c;
    logic                  wr_acc_c;
    logic                  rd_acc_c;
    logic                  rd_vld_c;
    logic                  act0_c;
    logic                  act1_c;
    logic                  pick_r1_c;
    logic                  done_c;

    // Owner mux toward the SPI master, gated by transfer direction
    always_comb begin
        sel_r1_c     = (owner_q == OWNER_R1);
        own_addr_c   = sel_r1_c ? r1.addr     : r0.addr;
        own_write_c  = sel_r1_c ? r1.write    : r0.write;
        own_read_c   = sel_r1_c ? r1.read     : r0.read;
        own_burst_c  = sel_r1_c ? r1.burstcnt : r0.burstcnt;
        own_wrdata_c = sel_r1_c ? r1.wrdata   : r0.wrdata;
        eff_burst_c  = (own_burst_c == '0) ? BRST_WIDTH'(1) : own_burst_c;
        m_write_c    = (state_q == ST_WR)     && own_write_c;
        m_read_c     = (state_q == ST_RD_CMD) && own_read_c;
        wr_acc_c     = m_write_c && !m.waitreq;
        rd_acc_c     = m_read_c  && !m.waitreq;
        // Response beats count in RD_WAIT and on the command-acceptance cycle
        rd_vld_c     = m.rddvld && ((state_q == ST_RD_WAIT) || rd_acc_c);
    end

    assign m.addr     = own_addr_c;
    assign m.write    = m_write_c;
    assign m.read     = m_read_c;
    assign m.burstcnt = own_burst_c;
    assign m.wrdata   = own_wrdata_c;

    // Only the owner sees m_waitreq, and only while its command phase is live
    assign r0.waitreq = ((state_q == ST_WR) || (state_q == ST_RD_CMD)) && (owner_q == OWNER_R0)
                        ? m.waitreq : 1'b1;
    assign r1.waitreq = ((state_q == ST_WR) || (state_q == ST_RD_CMD)) && (owner_q == OWNER_R1)
                        ? m.waitreq : 1'b1;
    assign r0.rddvld  = rd_vld_c && (owner_q == OWNER_R0);
    assign r1.rddvld  = rd_vld_c && (owner_q == OWNER_R1);
    assign r0.rddata  = m.rddata;
    assign r1.rddata  = m.rddata;

    assign arb_owner   = owner_q;
    assign arb_timeout = timeout_q;

    // Round-robin pick: on a tie, favour the requester not served last
    always_comb begin
        act0_c    = r0.read || r0.write;
        act1_c    = r1.read || r1.write;
        pick_r1_c = act1_c && (!act0_c || !last_grant_q);
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        first_d      = first_q;
        rd_cnt_d     = rd_cnt_q;
        to_cnt_d     = to_cnt_q;
        timeout_d    = 1'b0;
        done_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (act0_c || act1_c) begin
                    owner_d = pick_r1_c ? OWNER_R1 : OWNER_R0;
                    first_d = 1'b1;
                    // Write wins if the winner asserts both
                    if (pick_r1_c ? r1.write : r0.write) state_d = ST_WR;
                    else                                 state_d = ST_RD_CMD;
                end
            end
            ST_WR: begin
                if (wr_acc_c) begin
                    if (first_q) begin
                        beat_cnt_d = eff_burst_c - BRST_WIDTH'(1);
                        first_d    = 1'b0;
                        done_c     = (eff_burst_c == BRST_WIDTH'(1));
                    end else begin
                        beat_cnt_d = beat_cnt_q - BRST_WIDTH'(1);
                        done_c     = (beat_cnt_q == BRST_WIDTH'(1));
                    end
                end
            end
            ST_RD_CMD: begin
                if (rd_acc_c) begin
                    to_cnt_d = '0;
                    state_d  = ST_RD_WAIT;
                    if (m.rddvld) begin
                        rd_cnt_d = eff_burst_c - BRST_WIDTH'(1);
                        done_c   = (eff_burst_c == BRST_WIDTH'(1));
                    end else begin
                        rd_cnt_d = eff_burst_c;
                    end
                end
            end
            ST_RD_WAIT: begin
                // A data beat clears the timeout even when a tick coincides
                if (m.rddvld) begin
                    to_cnt_d = '0;
                    rd_cnt_d = rd_cnt_q - BRST_WIDTH'(1);
                    done_c   = (rd_cnt_q == BRST_WIDTH'(1));
                end else if (pulse_1us) begin
                    if (to_cnt_q == TO_LAST) begin
                        to_cnt_d  = '0;
                        rd_cnt_d  = '0;
                        timeout_d = 1'b1;
                        done_c    = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // End of grant always passes through IDLE before the next arbitration
        if (done_c) begin
            state_d      = ST_IDLE;
            owner_d      = OWNER_NONE;
            last_grant_d = sel_r1_c;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_NONE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            first_q      <= 1'b0;
            rd_cnt_q     <= '0;
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            first_q      <= first_d;
            rd_cnt_q     <= rd_cnt_d;
            to_cnt_q     <= to_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule
